memory_game_engine: RTL and testbench

MEMORY_GAME_ENGINE -- requirements
Module: memory_game_engine

---
 rtl/memory_game_engine.sv | 130 +++++++++++++
 tb/tb_memory_game_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_engine.sv
// memory_game_engine: pattern-memory game; shows a growing LED sequence, checks the
// player's button releases against it, and tracks score and misses.
module memory_game_engine #(
   parameter int NUM_BUTTONS   = 4,
   parameter int GAME_LIMIT    = 6,
   parameter int CLKS_PER_STEP = 6250000,
   parameter int TIMEOUT_CLKS  = 75000000,
   parameter int MAX_MISSES    = 3,
   localparam int ID_W = $clog2(NUM_BUTTONS)
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic [NUM_BUTTONS-1:0]     i_buttons,
   input  logic [GAME_LIMIT*ID_W-1:0] i_rand,
   output logic [NUM_BUTTONS-1:0]     o_leds,
   output logic [3:0]                 o_score,
   output logic [1:0]                 o_misses,
   output logic                       o_game_over
);
   localparam int SW = $clog2(CLKS_PER_STEP + 1);
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   typedef enum logic [2:0] {START, PATTERN_OFF, PATTERN_SHOW, WAIT_PLAYER, MISS, INCR_SCORE, WINNER, LOSER} state_t;
   state_t state, state_n;
   logic [NUM_BUTTONS-1:0] btn_q, rel_q;
   logic [GAME_LIMIT*ID_W-1:0] pattern;
   logic [3:0] score, idx;
   logic [1:0] misses;
   logic [SW-1:0] step;
   logic [TW-1:0] tmo;
   logic [ID_W-1:0] ev_id, cur;
   logic ev, hit, last, step_end, tmo_end, force_start;
   logic idx_clr, idx_inc, game_clr, score_inc, miss_inc;

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         btn_q <= '0;
         rel_q <= '0;
      end else begin
         btn_q <= i_buttons;
         rel_q <= btn_q & ~i_buttons;
      end

   // lowest released index wins; simultaneous others are dropped
   always_comb begin
      ev_id = '0;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--)
         if (rel_q[i]) ev_id = ID_W'(i);
   end

   assign ev          = |rel_q;
   assign cur         = pattern[idx*ID_W +: ID_W];
   assign hit         = ev_id == cur;
   assign last        = idx == score;
   assign step_end    = step == SW'(CLKS_PER_STEP - 1);
   assign tmo_end     = tmo == TW'(TIMEOUT_CLKS - 1);
   assign force_start = i_buttons[0] & i_buttons[1];

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) state <= START;
      else state <= state_n;

   always_comb begin
      state_n   = state;
      idx_clr   = 1'b0;
      idx_inc   = 1'b0;
      game_clr  = 1'b0;
      score_inc = 1'b0;
      miss_inc  = 1'b0;
      case (state)
         START: if (ev && !i_buttons[0] && !i_buttons[1]) begin
            game_clr = 1'b1;
            state_n  = PATTERN_OFF;
         end
         PATTERN_OFF: if (step_end) state_n = PATTERN_SHOW;
         PATTERN_SHOW: if (step_end) begin
            idx_clr = last;
            idx_inc = !last;
            state_n = last ? WAIT_PLAYER : PATTERN_OFF;
         end
         WAIT_PLAYER: if (ev) begin
            idx_clr = hit && last;
            idx_inc = hit && !last;
            state_n = !hit ? MISS : last ? INCR_SCORE : WAIT_PLAYER;
         end else if (tmo_end) state_n = MISS;
         MISS: begin
            miss_inc = 1'b1;
            idx_clr  = 1'b1;
            state_n  = (misses + 2'd1 == 2'(MAX_MISSES)) ? LOSER : PATTERN_OFF;
         end
         INCR_SCORE: begin
            score_inc = 1'b1;
            state_n   = (score == 4'(GAME_LIMIT - 1)) ? WINNER : PATTERN_OFF;
         end
         WINNER, LOSER: state_n = state;
         default: state_n = START;
      endcase
      if (force_start) begin
         idx_clr   = 1'b0;
         idx_inc   = 1'b0;
         game_clr  = 1'b0;
         score_inc = 1'b0;
         miss_inc  = 1'b0;
         state_n   = START;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         score  <= '0;
         misses <= '0;
         idx    <= '0;
         step   <= '0;
         tmo    <= '0;
      end else begin
         score  <= game_clr ? '0 : score + 4'(score_inc);
         misses <= game_clr ? '0 : misses + 2'(miss_inc);
         idx    <= (game_clr || idx_clr) ? '0 : idx + 4'(idx_inc);
         step   <= (state_n != state || !(state == PATTERN_OFF || state == PATTERN_SHOW)) ? '0 : step + 1'b1;
         tmo    <= (state != WAIT_PLAYER || ev) ? '0 : tmo + 1'b1;
      end

   // pattern has no reset: it is reloaded every cycle spent in START
   always_ff @(posedge i_clk)
      if (state == START) pattern <= i_rand;

   assign o_leds      = (state == PATTERN_SHOW) ? NUM_BUTTONS'(1) << cur : i_buttons;
   assign o_score     = (state == WINNER) ? 4'hA : (state == LOSER) ? 4'hF : score;
   assign o_misses    = misses;
   assign o_game_over = state == WINNER || state == LOSER;
endmodule

// File: tb/tb_memory_game_engine.sv
// tb_memory_game_engine: directed scenarios, a WINNER-state vector table and random games
// checked against a round-level model of the game rules.
module tb_memory_game_engine;
   localparam int NB = 4, GL = 3, CS = 4, TO = 20, MM = 2, IW = 2, RW = GL * IW;
   logic clk = 0, rst = 1;
   logic [NB-1:0] btn = '0;
   logic [RW-1:0] rnd = '0;
   logic [NB-1:0] leds;
   logic [3:0] score;
   logic [1:0] misses;
   logic over;
   int vecs = 0, bad = 0;
   int pat[GL];
   int m_score, m_miss;

   typedef struct {
      logic [3:0] b;
      logic [3:0] leds;
      logic       over;
      logic [3:0] score;
   } vec_t;
   vec_t tbl[8];

   always #5 clk = ~clk;

   memory_game_engine #(.NUM_BUTTONS(NB), .GAME_LIMIT(GL), .CLKS_PER_STEP(CS),
                        .TIMEOUT_CLKS(TO), .MAX_MISSES(MM)) dut (
      .i_clk(clk), .i_reset(rst), .i_buttons(btn), .i_rand(rnd),
      .o_leds(leds), .o_score(score), .o_misses(misses), .o_game_over(over));

   task automatic chk(input string name, input int got, input int exp);
      vecs++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_model(input logic [RW-1:0] r);
      for (int k = 0; k < GL; k++) pat[k] = int'(r[k*IW +: IW]);
      m_score = 0;
      m_miss  = 0;
   endtask

   task automatic tap(input int id);
      btn = 4'(1 << id);
      cyc(1);
      btn = '0;
      cyc(3);
   endtask

   // Follows n LED pulses, checking each shown id and its length; returns on the
   // first dark sample after the last pulse, i.e. the first cycle of the player's turn.
   task automatic watch(input int n);
      int cnt, len, t;
      bit on;
      cnt = 0; len = 0; t = 0; on = 0;
      while (t < 400) begin
         @(negedge clk);
         t++;
         if (leds != 0) begin
            if (!on) begin
               on  = 1;
               len = 0;
               if (cnt < GL) chk("show_id", int'(leds), 1 << pat[cnt]);
            end
            len++;
         end else if (on) begin
            on = 0;
            chk("show_len", len, CS);
            cnt++;
            if (cnt == n) return;
         end
      end
      chk("show_timeout", cnt, n);
   endtask

   task automatic start_game(input logic [RW-1:0] r);
      rnd = r;
      load_model(r);
      tap(2);
      rnd = RW'($urandom);
   endtask

   task automatic expect_state();
      if (m_miss == MM) begin
         chk("loss_score", int'(score), 15);
         chk("loss_over", int'(over), 1);
      end else if (m_score == GL) begin
         chk("win_score", int'(score), 10);
         chk("win_over", int'(over), 1);
      end else begin
         chk("score", int'(score), m_score);
         chk("over", int'(over), 0);
      end
      chk("misses", int'(misses), m_miss);
   endtask

   // kind 0: perfect round; 1: wrong release at position wj (id wid, or random if < 0); 2: timeout
   task automatic play_round(input int kind, input int wj, input int wid);
      int s;
      s = m_score;
      watch(s + 1);
      if (kind == 0) begin
         for (int j = 0; j <= s; j++) tap(pat[j]);
         m_score++;
      end else if (kind == 1) begin
         for (int j = 0; j < wj; j++) tap(pat[j]);
         tap(wid >= 0 ? wid : (pat[wj] + 1 + int'($urandom_range(2, 0))) % NB);
         m_miss++;
      end else begin
         cyc(TO);
         chk("timeout_edge", int'(misses), m_miss);
         cyc(1);
         m_miss++;
      end
      expect_state();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int k, h, t;
      tbl[0] = '{4'b0001, 4'b0001, 1'b1, 4'hA};
      tbl[1] = '{4'b0100, 4'b0100, 1'b1, 4'hA};
      tbl[2] = '{4'b1000, 4'b1000, 1'b1, 4'hA};
      tbl[3] = '{4'b0000, 4'b0000, 1'b1, 4'hA};
      tbl[4] = '{4'b1110, 4'b1110, 1'b1, 4'hA};
      tbl[5] = '{4'b0110, 4'b0110, 1'b1, 4'hA};
      tbl[6] = '{4'b1010, 4'b1010, 1'b1, 4'hA};
      tbl[7] = '{4'b0011, 4'b0011, 1'b0, 4'h0};

      cyc(2);
      chk("rst_leds", int'(leds), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_misses", int'(misses), 0);
      chk("rst_over", int'(over), 0);
      rst = 0;
      cyc(2);

      // first round shows LED3, replay shows LED3 then LED1, perfect play wins
      start_game(6'b10_01_11);
      play_round(0, 0, -1);
      play_round(0, 0, -1);
      play_round(0, 0, -1);
      h = 0;
      repeat (100) begin
         @(negedge clk);
         if (score != 4'hA || !over) h++;
      end
      chk("win_hold", h, 0);

      for (int i = 0; i < 8; i++) begin
         btn = tbl[i].b;
         #1;
         chk("tbl_echo", int'(leds), int'(tbl[i].leds));
         @(negedge clk);
         chk("tbl_over", int'(over), int'(tbl[i].over));
         if (tbl[i].over) chk("tbl_score", int'(score), int'(tbl[i].score));
      end
      rst = 1; btn = '0; cyc(2); rst = 0; cyc(1);

      // wrong button 0 instead of 3 twice -> one miss with replay, then loss
      start_game(6'b10_01_11);
      play_round(1, 0, 0);
      play_round(1, 0, 0);
      rst = 1; cyc(2); rst = 0; cyc(1);

      // timeout miss, then a release in the last allowed cycle avoids a miss
      start_game(6'b10_01_11);
      play_round(2, 0, -1);
      play_round(0, 0, -1);
      watch(2);
      cyc(16);
      btn = 4'(1 << pat[0]);
      cyc(2);
      btn = '0;
      cyc(3);
      chk("late_release_no_miss", int'(misses), 1);
      tap(pat[1]);
      m_score++;
      expect_state();
      rst = 1; cyc(2); rst = 0; cyc(1);

      // buttons 0+1 during PATTERN_SHOW force START; release restarts a fresh game
      start_game(RW'($urandom));
      play_round(0, 0, -1);
      t = 0;
      while (leds == 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("show_seen", int'(leds != 0), 1);
      btn = 4'b0011;
      @(negedge clk);
      chk("force_leds", int'(leds), 3);
      cyc(2);
      btn = '0;
      cyc(3);
      chk("force_restart_score", int'(score), 0);
      load_model(rnd);
      play_round(1, 0, -1);
      play_round(0, 0, -1);
      watch(2);
      btn = 4'b0100;
      cyc(1);
      rst = 1;
      btn = '0;
      #1;
      chk("async_rst_leds", int'(leds), 0);
      chk("async_rst_score", int'(score), 0);
      chk("async_rst_misses", int'(misses), 0);
      chk("async_rst_over", int'(over), 0);
      #1 rst = 0;
      h = 0;
      repeat (30) begin
         @(negedge clk);
         if (leds != 0) h++;
      end
      chk("no_spurious_start", h, 0);
      chk("post_rst_score", int'(score), 0);

      for (int g = 0; g < 6; g++) begin
         rst = 1; cyc(1); rst = 0; cyc(1);
         start_game(RW'($urandom));
         while (!(m_miss == MM || m_score == GL)) begin
            k = int'($urandom_range(9, 0));
            play_round(k < 6 ? 0 : k < 8 ? 1 : 2, int'($urandom_range(m_score, 0)), -1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end
endmodule
